// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types for the run controller.
//   cmd_op_e     : host/debug command opcodes
//   stop_cause_e : reason the last run ended
//   state_e      : controller FSM states
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HALT  = 2'd0,
    OP_STEP  = 2'd1,
    OP_RUN   = 2'd2,
    OP_RUN_N = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    SC_NONE       = 2'd0,
    SC_CMD_HALT   = 2'd1,
    SC_COUNT_DONE = 2'd2,
    SC_BREAKPOINT = 2'd3
  } stop_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/run_ctrl.sv
// run_ctrl: sequences the CPU execution FSM from host/debug commands.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake; cmd_op, cmd_arg payload
//   bp_en, bp_addr             : breakpoint enable/address
//   pc, instr_query, cpu_run   : status from exe FSM
//   fetch_ready                : instruction memory word delivered
//   exe_start, exe_run         : controls to exe FSM
//   halted, stop_cause         : controller idle flag, reason for last stop
//   retired_cnt                : saturating count of retired instructions
//   cmd_err                    : sticky, non-HALT command accepted while active
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             instr_query,
  input  logic             cpu_run,
  input  logic             fetch_ready,
  output logic             exe_start,
  output logic             exe_run,
  output logic             halted,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             cmd_err
);

  state_e           r_state;
  stop_cause_e      r_stop_cause;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_retired;
  logic             r_unlimited;
  logic             r_halt_pend;
  logic             r_cmd_err;
  logic             r_halted;
  logic             r_cmd_ready;

  cmd_op_e          w_op;
  logic             w_accept;
  logic             w_active;
  logic             w_halt_now;
  logic             w_bp_hit;
  logic             w_cnt_done;
  logic             w_stop;
  logic             w_launch_req;
  stop_cause_e      w_cause;

  assign w_op       = cmd_op_e'(cmd_op);
  assign w_accept   = cmd_valid & r_cmd_ready;
  assign w_active   = (r_state == ST_ACTIVE);
  assign w_halt_now = w_accept & (w_op == OP_HALT);
  assign w_bp_hit   = bp_en & (pc == bp_addr);
  assign w_cnt_done = ~r_unlimited & (r_remaining == CNT_W'(1));
  assign w_stop     = w_active & cpu_run &
                      (w_bp_hit | w_cnt_done | r_halt_pend | w_halt_now);

  // RUN_N with a zero count never launches; it only reports COUNT_DONE.
  assign w_launch_req = (r_state == ST_IDLE) & w_accept &
                        ((w_op == OP_STEP) | (w_op == OP_RUN) |
                         ((w_op == OP_RUN_N) & (cmd_arg != '0)));

  always_comb begin
    w_cause = SC_CMD_HALT;
    if (w_bp_hit)        w_cause = SC_BREAKPOINT;
    else if (w_cnt_done) w_cause = SC_COUNT_DONE;
  end

  // The stop pulse shares exe_start with the launch pulse so the exe FSM
  // leaves RUNING in the same cycle as the final instruction retires.
  assign exe_start   = (r_state == ST_LAUNCH) | w_stop;
  assign exe_run     = w_active & instr_query & fetch_ready;
  assign cmd_ready   = r_cmd_ready;
  assign halted      = r_halted;
  assign stop_cause  = r_stop_cause;
  assign retired_cnt = r_retired;
  assign cmd_err     = r_cmd_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_stop_cause <= SC_NONE;
      r_remaining  <= '0;
      r_retired    <= '0;
      r_unlimited  <= 1'b0;
      r_halt_pend  <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_halted     <= 1'b1;
      r_cmd_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch_req) begin
            r_state      <= ST_LAUNCH;
            r_retired    <= '0;
            r_stop_cause <= SC_NONE;
            r_halt_pend  <= 1'b0;
            r_halted     <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_unlimited  <= (w_op == OP_RUN);
            r_remaining  <= (w_op == OP_STEP) ? CNT_W'(1) : cmd_arg;
          end else if (w_accept & (w_op == OP_RUN_N)) begin
            r_stop_cause <= SC_COUNT_DONE;
          end
        end
        ST_LAUNCH: begin
          r_state     <= ST_ACTIVE;
          r_cmd_ready <= 1'b1;
        end
        ST_ACTIVE: begin
          if (w_accept) begin
            if (w_op == OP_HALT) r_halt_pend <= 1'b1;
            else                 r_cmd_err   <= 1'b1;
          end
          if (cpu_run) begin
            if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
            if (!r_unlimited)    r_remaining <= r_remaining - CNT_W'(1);
          end
          if (w_stop) begin
            r_state      <= ST_IDLE;
            r_stop_cause <= w_cause;
            r_halted     <= 1'b1;
            r_halt_pend  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl with a small behavioural
// stand-in for exe_fsm (IDLE -> FETCH -> EXEC -> FETCH ...).
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        instr_query;
  logic        cpu_run;
  logic        fetch_ready;
  logic        exe_start;
  logic        exe_run;
  logic        halted;
  logic [1:0]  stop_cause;
  logic [15:0] retired_cnt;
  logic        cmd_err;

  run_ctrl #(.PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .instr_query(instr_query), .cpu_run(cpu_run), .fetch_ready(fetch_ready),
    .exe_start(exe_start), .exe_run(exe_run), .halted(halted),
    .stop_cause(stop_cause), .retired_cnt(retired_cnt), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // exe FSM stand-in
  logic [1:0]  m_st;
  logic [31:0] m_pc;
  logic [7:0]  m_fcnt;
  logic [7:0]  fr_delay;
  logic        burst;

  assign pc          = m_pc;
  assign instr_query = (m_st == 2'd1);
  assign cpu_run     = (m_st == 2'd2) | burst;
  assign fetch_ready = (fr_delay == 8'd0) ? 1'b1 : ((m_st == 2'd1) && (m_fcnt >= fr_delay));

  always @(posedge clk) begin
    if (reset) begin
      m_st <= 2'd0; m_pc <= '0; m_fcnt <= '0;
    end else begin
      case (m_st)
        2'd0: if (exe_start) begin m_st <= 2'd1; m_pc <= '0; m_fcnt <= '0; end
        2'd1: if (exe_start) m_st <= 2'd0;
              else if (exe_run) m_st <= 2'd2;
              else m_fcnt <= m_fcnt + 8'd1;
        default: begin
          m_pc <= m_pc + 32'd4; m_fcnt <= '0;
          m_st <= exe_start ? 2'd0 : 2'd1;
        end
      endcase
    end
  end

  // event counters
  int n_cpu = 0, n_start = 0, n_start_run = 0, n_bad_run = 0;
  always @(posedge clk) begin
    if (!reset) begin
      if (cpu_run) n_cpu <= n_cpu + 1;
      if (exe_start) n_start <= n_start + 1;
      if (exe_start & cpu_run) n_start_run <= n_start_run + 1;
      if (exe_run & !(instr_query & fetch_ready)) n_bad_run <= n_bad_run + 1;
    end
  end

  int passes = 0, total = 0;
  int s_cpu, s_start, s_start_run, s_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic snap();
    s_cpu = n_cpu; s_start = n_start; s_start_run = n_start_run; s_bad = n_bad_run;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    bp_en = 1'b0; bp_addr = '0; fr_delay = '0; burst = 1'b0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_halted", {31'd0, halted}, 1);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_exe_start", {31'd0, exe_start}, 0);
    chk("rst_exe_run", {31'd0, exe_run}, 0);
    chk("rst_stop_cause", {30'd0, stop_cause}, 0);
    chk("rst_retired", {16'd0, retired_cnt}, 0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // STEP, fetch_ready tied high
    snap();
    do_cmd(OP_STEP, 16'd0);
    chk("step_launch_start", {31'd0, exe_start}, 1);
    chk("step_launch_ready", {31'd0, cmd_ready}, 0);
    chk("step_launch_halted", {31'd0, halted}, 0);
    wait_halted("step_wait", 50);
    chk("step_cpu_runs", n_cpu - s_cpu, 1);
    chk("step_starts", n_start - s_start, 2);
    chk("step_stop_with_run", n_start_run - s_start_run, 1);
    chk("step_retired", {16'd0, retired_cnt}, 1);
    chk("step_cause", {30'd0, stop_cause}, SC_COUNT_DONE);

    // RUN_N 5 with 3-cycle fetch delay
    fr_delay = 8'd3;
    snap();
    do_cmd(OP_RUN_N, 16'd5);
    wait_halted("runn5_wait", 200);
    chk("runn5_cpu_runs", n_cpu - s_cpu, 5);
    chk("runn5_bad_exe_run", n_bad_run - s_bad, 0);
    chk("runn5_retired", {16'd0, retired_cnt}, 5);
    chk("runn5_cause", {30'd0, stop_cause}, SC_COUNT_DONE);

    // RUN with breakpoint at 0x10
    fr_delay = 8'd0; bp_en = 1'b1; bp_addr = 32'h10;
    do_cmd(OP_RUN, 16'd0);
    wait_halted("bp_wait", 100);
    chk("bp_retired", {16'd0, retired_cnt}, 5);
    chk("bp_cause", {30'd0, stop_cause}, SC_BREAKPOINT);

    // RUN without breakpoint passes 0x10, then HALT mid-fetch
    bp_en = 1'b0; fr_delay = 8'd2;
    snap();
    do_cmd(OP_RUN, 16'd0);
    for (int i = 0; i < 200 && !((n_cpu - s_cpu) == 8 && instr_query); i++) @(negedge clk);
    chk("nobp_running", {31'd0, halted}, 0);
    chk("nobp_count8", n_cpu - s_cpu, 8);
    do_cmd(OP_HALT, 16'd0);
    wait_halted("halt_fetch_wait", 50);
    chk("halt_fetch_retired", {16'd0, retired_cnt}, 9);
    chk("halt_fetch_cause", {30'd0, stop_cause}, SC_CMD_HALT);

    // HALT accepted in the same cycle as cpu_run
    fr_delay = 8'd1;
    snap();
    do_cmd(OP_RUN, 16'd0);
    for (int i = 0; i < 100 && !((n_cpu - s_cpu) == 2 && cpu_run); i++) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    #1;
    chk("halt_same_start", {31'd0, exe_start}, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("halt_same_halted", {31'd0, halted}, 1);
    chk("halt_same_retired", {16'd0, retired_cnt}, 3);
    chk("halt_same_cause", {30'd0, stop_cause}, SC_CMD_HALT);

    // STEP while ACTIVE: error flag only
    snap();
    do_cmd(OP_RUN_N, 16'd4);
    for (int i = 0; i < 100 && (n_cpu - s_cpu) != 1; i++) @(negedge clk);
    chk("err_before", {31'd0, cmd_err}, 0);
    do_cmd(OP_STEP, 16'd0);
    chk("err_set", {31'd0, cmd_err}, 1);
    wait_halted("err_wait", 100);
    chk("err_retired", {16'd0, retired_cnt}, 4);
    chk("err_cause", {30'd0, stop_cause}, SC_COUNT_DONE);

    // RUN_N 1 hitting breakpoint on the same instruction
    fr_delay = 8'd0; bp_en = 1'b1; bp_addr = 32'h0;
    do_cmd(OP_RUN_N, 16'd1);
    wait_halted("prio_wait", 50);
    chk("prio_retired", {16'd0, retired_cnt}, 1);
    chk("prio_cause", {30'd0, stop_cause}, SC_BREAKPOINT);
    bp_en = 1'b0;

    // RUN_N 0 and HALT in IDLE
    snap();
    do_cmd(OP_RUN_N, 16'd0);
    chk("runn0_halted", {31'd0, halted}, 1);
    chk("runn0_cause", {30'd0, stop_cause}, SC_COUNT_DONE);
    repeat (3) @(negedge clk);
    chk("runn0_no_start", n_start - s_start, 0);
    chk("runn0_still_halted", {31'd0, halted}, 1);
    do_cmd(OP_HALT, 16'd0);
    chk("idle_halt_cause", {30'd0, stop_cause}, SC_COUNT_DONE);

    // reset while ACTIVE
    fr_delay = 8'd1;
    do_cmd(OP_RUN, 16'd0);
    repeat (6) @(negedge clk);
    chk("mid_active", {31'd0, halted}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_halted", {31'd0, halted}, 1);
    chk("mrst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("mrst_exe_start", {31'd0, exe_start}, 0);
    chk("mrst_exe_run", {31'd0, exe_run}, 0);
    chk("mrst_stop_cause", {30'd0, stop_cause}, 0);
    chk("mrst_retired", {16'd0, retired_cnt}, 0);
    chk("mrst_cmd_err", {31'd0, cmd_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // retired_cnt saturation with a long back-to-back RUN
    fr_delay = 8'd0;
    do_cmd(OP_RUN, 16'd0);
    burst = 1'b1;
    repeat (65540) @(negedge clk);
    chk("sat_running", {31'd0, halted}, 0);
    chk("sat_value", {16'd0, retired_cnt}, 32'hFFFF);
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    #1;
    chk("sat_halt_start", {31'd0, exe_start}, 1);
    @(negedge clk);
    cmd_valid = 1'b0; burst = 1'b0;
    chk("sat_halted", {31'd0, halted}, 1);
    chk("sat_final", {16'd0, retired_cnt}, 32'hFFFF);
    chk("sat_cause", {30'd0, stop_cause}, SC_CMD_HALT);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
